// File: rtl/saph_fpu_dispatch.sv
`default_nettype none
// ============================================================================
// saph_fpu_dispatch
// Round-robin issue of one float request stream to FPUS units; responses are
// returned in issue order through an order FIFO.            Rev 1.0
// ============================================================================
module saph_fpu_dispatch #(
    parameter int FPUS = 4,
    parameter int WIDTH = 32,
    parameter int MODES = 4,
    parameter int DEPTH = 8,
    parameter logic [WIDTH-1:0] ERR_VALUE = 32'h7FC00000,
    localparam int MB = (MODES > 1) ? $clog2(MODES) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WIDTH-1:0]        req_lhs,
    input  logic [WIDTH-1:0]        req_rhs,
    input  logic [MB-1:0]           req_mode,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_res,
    output logic                    rsp_err,
    output logic [MODES-1:0]        has_modes,
    output logic [CW-1:0]           outstanding,
    input  logic [FPUS*MODES-1:0]   fpu_modes,
    input  logic [FPUS-1:0]         fpu_ready,
    output logic [FPUS-1:0]         fpu_trig,
    output logic [WIDTH-1:0]        fpu_lhs,
    output logic [WIDTH-1:0]        fpu_rhs,
    output logic [MB-1:0]           fpu_mode,
    input  logic [FPUS-1:0]         fpu_res_valid,
    input  logic [FPUS*WIDTH-1:0]   fpu_res,
    output logic [FPUS-1:0]         fpu_res_ready
);

    localparam int IW = (FPUS > 1) ? $clog2(FPUS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [MB:0]   C_MODES = (MB + 1)'(MODES);
    localparam logic [IW-1:0] C_LAST  = IW'(FPUS - 1);

    logic [IW-1:0]    r_rr_last;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [IW-1:0]    r_fifo_idx [DEPTH];
    logic             r_fifo_err [DEPTH];

    logic             w_mode_ok;
    logic             w_any_cap;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_found;
    logic [FPUS-1:0]  w_elig;
    logic [IW-1:0]    w_grant;
    logic [IW-1:0]    w_head_idx;
    logic             w_head_err;
    logic [WIDTH-1:0] w_unit_res [FPUS];

    // Guards non-power-of-two MODES against out-of-range mode codes.
    assign w_mode_ok = ({1'b0, req_mode} < C_MODES);

    always_comb begin
        has_modes = '0;
        for (int x = 0; x < FPUS; x++) begin
            has_modes = has_modes | fpu_modes[x*MODES +: MODES];
        end
    end

    generate
        for (genvar x = 0; x < FPUS; x++) begin : g_unit
            logic [MODES-1:0] w_umask;
            assign w_umask       = fpu_modes[x*MODES +: MODES];
            assign w_elig[x]     = w_mode_ok && w_umask[req_mode] && fpu_ready[x];
            assign w_unit_res[x] = fpu_res[x*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_any_cap  = w_mode_ok && has_modes[req_mode];
    assign w_full     = (r_count == C_DEPTH);
    assign w_empty    = (r_count == '0);
    assign req_ready  = rst_n && !w_full && ((|w_elig) || !w_any_cap);
    assign w_push     = req_valid && req_ready;
    assign w_head_idx = r_fifo_idx[r_rd_ptr];
    assign w_head_err = r_fifo_err[r_rd_ptr];

    // Round-robin scan starting one past the last granted unit.
    always_comb begin
        int c;
        c       = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 1; i <= FPUS; i++) begin
            c = int'(r_rr_last) + i;
            if (c >= FPUS) begin
                c = c - FPUS;
            end
            if (!w_found && w_elig[c[IW-1:0]]) begin
                w_found = 1'b1;
                w_grant = c[IW-1:0];
            end
        end
    end

    always_comb begin
        fpu_trig = '0;
        if (w_push && w_any_cap && w_found) begin
            fpu_trig[w_grant] = 1'b1;
        end
    end

    assign fpu_lhs  = req_lhs;
    assign fpu_rhs  = req_rhs;
    assign fpu_mode = req_mode;

    always_comb begin
        rsp_valid     = 1'b0;
        rsp_res       = '0;
        rsp_err       = 1'b0;
        fpu_res_ready = '0;
        if (!w_empty) begin
            if (w_head_err) begin
                rsp_valid = rst_n;
                rsp_res   = ERR_VALUE;
                rsp_err   = 1'b1;
            end else begin
                rsp_valid = rst_n && fpu_res_valid[w_head_idx];
                rsp_res   = w_unit_res[w_head_idx];
                fpu_res_ready[w_head_idx] = rst_n && rsp_ready;
            end
        end
    end

    assign w_pop       = rsp_valid && rsp_ready;
    assign outstanding = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= w_grant;
            r_fifo_err[r_wr_ptr] <= !w_any_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rr_last <= C_LAST;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_any_cap) begin
                    r_rr_last <= w_grant;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_saph_fpu_dispatch.sv
`default_nettype none
// ============================================================================
// tb_saph_fpu_dispatch
// Directed + random checks of saph_fpu_dispatch against a queue-based model.
// Rev 1.0
// ============================================================================
module tb_saph_fpu_dispatch;

    localparam int FPUS  = 4;
    localparam int WIDTH = 32;
    localparam int MODES = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] ERRV = 32'h7FC00000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [WIDTH-1:0]      req_lhs;
    logic [WIDTH-1:0]      req_rhs;
    logic [1:0]            req_mode;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_res;
    logic                  rsp_err;
    logic [MODES-1:0]      has_modes;
    logic [3:0]            outstanding;
    logic [FPUS*MODES-1:0] fpu_modes;
    logic [FPUS-1:0]       fpu_ready;
    logic [FPUS-1:0]       fpu_trig;
    logic [WIDTH-1:0]      fpu_lhs;
    logic [WIDTH-1:0]      fpu_rhs;
    logic [1:0]            fpu_mode;
    logic [FPUS-1:0]       fpu_res_valid;
    logic [FPUS*WIDTH-1:0] fpu_res;
    logic [FPUS-1:0]       fpu_res_ready;

    always #5 clk = ~clk;

    saph_fpu_dispatch #(
        .FPUS(FPUS), .WIDTH(WIDTH), .MODES(MODES), .DEPTH(DEPTH), .ERR_VALUE(ERRV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_lhs(req_lhs), .req_rhs(req_rhs), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .has_modes(has_modes), .outstanding(outstanding),
        .fpu_modes(fpu_modes), .fpu_ready(fpu_ready), .fpu_trig(fpu_trig),
        .fpu_lhs(fpu_lhs), .fpu_rhs(fpu_rhs), .fpu_mode(fpu_mode),
        .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res),
        .fpu_res_ready(fpu_res_ready)
    );

    typedef struct {
        bit          err;
        int          unit;
        logic [31:0] val;
    } ent_t;

    ent_t             mq[$];
    int               rr;
    logic [31:0]      uq_val[FPUS][$];
    int               uq_due[FPUS][$];
    logic [MODES-1:0] mask[FPUS];
    int               lat[FPUS];
    int               cyc;
    int               checks;
    int               failures;

    function automatic logic [31:0] fres(logic [31:0] a, logic [31:0] b, logic [1:0] m);
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, m};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        req_lhs = $urandom;
        req_rhs = $urandom;
    endtask

    task automatic clear_units();
        for (int u = 0; u < FPUS; u++) begin
            uq_val[u].delete();
            uq_due[u].delete();
        end
    endtask

    // One clock: drive unit outputs, compare DUT against model, then advance both.
    task automatic tick();
        logic [MODES-1:0] hm;
        logic [FPUS-1:0]  elig;
        logic [FPUS-1:0]  exp_trig;
        logic [FPUS-1:0]  exp_rr;
        bit               any_cap;
        bit               exp_rdy;
        bit               exp_v;
        int               g;
        ent_t             h;
        h = '{err: 1'b0, unit: 0, val: 32'd0};
        for (int u = 0; u < FPUS; u++) begin
            fpu_modes[u*MODES +: MODES] = mask[u];
            fpu_res_valid[u] = (uq_val[u].size() > 0) && (uq_due[u][0] <= cyc);
            fpu_res[u*WIDTH +: WIDTH] = (uq_val[u].size() > 0) ? uq_val[u][0] : 32'd0;
        end
        #1;
        hm = '0;
        for (int u = 0; u < FPUS; u++) hm = hm | mask[u];
        any_cap = hm[req_mode];
        for (int u = 0; u < FPUS; u++) elig[u] = mask[u][req_mode] && fpu_ready[u];
        exp_rdy = rst_n && (mq.size() < DEPTH) && ((elig != 0) || !any_cap);
        g = -1;
        if (exp_rdy && req_valid && any_cap) begin
            for (int i = 1; i <= FPUS; i++) begin
                if (g < 0 && elig[(rr + i) % FPUS]) g = (rr + i) % FPUS;
            end
        end
        exp_trig = (g >= 0) ? FPUS'(1) << g : '0;
        exp_v  = 1'b0;
        exp_rr = '0;
        if (mq.size() > 0) begin
            h = mq[0];
            exp_v = rst_n && (h.err || fpu_res_valid[h.unit]);
            if (rst_n && !h.err && rsp_ready) exp_rr = FPUS'(1) << h.unit;
        end
        chk("has_modes", 64'(has_modes), 64'(hm));
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("fpu_trig", 64'(fpu_trig), 64'(exp_trig));
        chk("outstanding", 64'(outstanding), 64'(mq.size()));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        chk("fpu_res_ready", 64'(fpu_res_ready), 64'(exp_rr));
        chk("fpu_lhs", 64'(fpu_lhs), 64'(req_lhs));
        if (exp_v) begin
            chk("rsp_res", 64'(rsp_res), 64'(h.err ? ERRV : h.val));
            chk("rsp_err", 64'(rsp_err), 64'(h.err));
        end else if (rst_n && mq.size() == 0) begin
            chk("rsp_res_empty", 64'(rsp_res), 64'd0);
        end
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            mq.delete();
            rr = FPUS - 1;
            clear_units();
        end else begin
            if (exp_v && rsp_ready) begin
                void'(mq.pop_front());
                if (!h.err) begin
                    void'(uq_val[h.unit].pop_front());
                    void'(uq_due[h.unit].pop_front());
                end
            end
            if (exp_rdy && req_valid) begin
                mq.push_back('{err: !any_cap, unit: (g < 0) ? 0 : g,
                               val: fres(req_lhs, req_rhs, req_mode)});
                if (g >= 0) begin
                    rr = g;
                    uq_val[g].push_back(fres(req_lhs, req_rhs, req_mode));
                    uq_due[g].push_back(cyc + lat[g] - 1);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_masks(input logic [MODES-1:0] m);
        for (int u = 0; u < FPUS; u++) mask[u] = m;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; rr = FPUS - 1;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_mode = 2'd0;
        req_lhs = '0; req_rhs = '0; fpu_ready = '1;
        fpu_res_valid = '0; fpu_res = '0; fpu_modes = '0;
        set_masks(4'hF);
        for (int u = 0; u < FPUS; u++) lat[u] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Back-to-back fill, then a pop on the full cycle.
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rand_ops(); req_mode = 2'(i);
            tick();
        end
        chk("fill_count", 64'(outstanding), 64'd8);
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = 1'b0;
        repeat (12) tick();

        // Slow unit 0 ahead of fast unit 1.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        lat[0] = 5; lat[1] = 1; rsp_ready = 1'b1;
        req_valid = 1'b1;
        rand_ops(); tick();
        rand_ops(); tick();
        req_valid = 1'b0;
        repeat (8) tick();

        // Unsupported mode queued behind a normal request.
        set_masks(4'h7);
        req_valid = 1'b1; rsp_ready = 1'b0;
        req_mode = 2'd0; rand_ops(); tick();
        req_mode = 2'd3; rand_ops(); tick();
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (8) tick();

        // Only unit 2 handles mode 1 and is initially busy.
        set_masks(4'b0001); mask[2] = 4'b0010;
        fpu_ready[2] = 1'b0;
        req_valid = 1'b1; req_mode = 2'd1; rand_ops();
        tick();
        fpu_ready[2] = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();

        // Reset with requests in flight; first grant must return to unit 0.
        set_masks(4'hF); rsp_ready = 1'b0; req_valid = 1'b1; req_mode = 2'd2;
        repeat (5) begin rand_ops(); tick(); end
        req_valid = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req_valid = 1'b1; rand_ops(); tick();
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) tick();

        // Randomized traffic.
        for (int u = 0; u < FPUS; u++) lat[u] = $urandom_range(1, 6);
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) begin
                for (int u = 0; u < FPUS; u++) mask[u] = 4'($urandom_range(0, 15));
                mask[$urandom_range(0, FPUS - 1)][0] = 1'b1;
            end
            req_valid = ($urandom_range(0, 3) != 0);
            req_mode  = 2'($urandom_range(0, 3));
            rand_ops();
            fpu_ready = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = (n % 257 != 256);
            tick();
        end
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/saph_fpu_dispatch.md
Name: saph_fpu_dispatch

Overview:
Successor to the single-request FPU demultiplexer: fans one GPU float request stream out to FPUS parametrised, variable-latency FPU units.
- Unit choice is round-robin among units that support the requested mode and are ready.
- Results return to the GPU strictly in issue order via an internal order FIFO, so units may finish out of order relative to each other.
- Requests whose mode no unit supports are completed with an error response instead of stalling.

Parameters:
FPUS, 4, number of FPU units (1..16).
WIDTH, 32, operand/result width in bits.
MODES, 4, number of operation modes; mode field is $clog2(MODES) bits (min 1).
DEPTH, 8, order FIFO entries = max outstanding requests (power of 2, >=2).
ERR_VALUE, 32'h7FC00000, result returned for unsupported modes (WIDTH bits).

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-low
req_valid  in  1  GPU request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_lhs  in  WIDTH  left operand
req_rhs  in  WIDTH  right operand
req_mode  in  MB  operation mode, where MB = $clog2(MODES)
rsp_valid  out  1  response valid
rsp_ready  in  1  GPU accepts response
rsp_res  out  WIDTH  result
rsp_err  out  1  1 = mode unsupported, rsp_res = ERR_VALUE
has_modes  out  MODES  OR of all unit mode masks
outstanding  out  $clog2(DEPTH+1)  FIFO occupancy
fpu_modes  in  FPUS*MODES  per-unit supported-mode mask, unit x at [x*MODES +: MODES]
fpu_ready  in  FPUS  unit can accept a request this cycle
fpu_trig  out  FPUS  one-hot issue strobe
fpu_lhs/fpu_rhs  out  WIDTH  broadcast operands
fpu_mode  out  MB  broadcast mode
fpu_res_valid  in  FPUS  unit result valid
fpu_res  in  FPUS*WIDTH  unit results
fpu_res_ready  out  FPUS  result pop strobe per unit

Behaviour:
Eligibility and issue:
- elig[x] = fpu_modes[x][req_mode] && fpu_ready[x].
- any_cap = has_modes[req_mode].
- full = (outstanding == DEPTH).
- req_ready = !full && (elig != 0 || !any_cap).
- Accept (req_valid && req_ready && any_cap): fpu_trig = one-hot of the first elig unit scanning from rr_last+1 upward with wrap. The issue path is combinational, same cycle. Push the unit index to the FIFO with err=0. rr_last <= granted index.
- Accept with !any_cap: no fpu_trig; push an entry with err=1.
- fpu_trig is all zero whenever no accept occurs. Operand and mode broadcasts always follow the req_* inputs.

Response:
- Head entry h.
- If h.err: rsp_valid=1, rsp_res=ERR_VALUE, rsp_err=1.
- Otherwise: rsp_valid = fpu_res_valid[h.idx], rsp_res = fpu_res slice h.idx, rsp_err=0.
- fpu_res_ready[h.idx] = rsp_ready && !h.err && FIFO non-empty; every other fpu_res_ready bit is 0.
- Pop on rsp_valid && rsp_ready.
- rsp_valid=0 and rsp_res=0 when the FIFO is empty.
- Each unit is required to return its own results in its own issue order. Results from non-head units wait, held by their own valid/ready handshake.

FIFO:
- Circular buffer with wr_ptr/rd_ptr wrap at DEPTH.
- outstanding += push - pop.
- Push and pop in the same cycle leave the count unchanged.
- When full, req_ready=0 even if a pop occurs that cycle; there is no bypass.
- Pop while empty cannot occur, because rsp_valid=0.

Reset (rst_n=0 at a clk edge):
- wr_ptr=rd_ptr=0, outstanding=0, rr_last=FPUS-1, so unit 0 has first priority.
- Results still in flight inside units are discarded by ownership: units are reset by the same rst_n.
- During reset, req_ready=0 and rsp_valid=0. All fpu_trig and fpu_res_ready bits are 0.

Test Plan:
1. FPUS=4, all units support all modes and are ready; issue 8 back-to-back requests -> fpu_trig sequence 0001,0010,0100,1000,0001,...; outstanding reaches 8; req_ready=0 on the 9th.
2. Unit 0 latency 5, unit 1 latency 1; issue A->u0 then B->u1 -> rsp for B is withheld until A returns; responses arrive in order A, B, and fpu_res_ready[1] stays 0 while A is at the head.
3. req_mode=3 with no unit's bit 3 set -> accepted in 1 cycle with no fpu_trig; rsp_res=32'h7FC00000, rsp_err=1, in FIFO order behind earlier requests.
4. Only unit 2 supports mode 1; fpu_ready[2]=0 -> req_ready=0. fpu_ready[2] rises -> fpu_trig=0100 in the same cycle.
5. FIFO full with rsp_ready=1 popping -> req_ready stays 0 that cycle and rises the next; outstanding goes 8 -> 7.
6. rst_n=0 with 5 outstanding -> next cycle outstanding=0, rsp_valid=0; the first request after reset goes to unit 0.
